// File: rtl/code_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | code_seq_pkg : shared types and code arithmetic for code_sequencer          |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package code_seq_pkg;

  localparam int CODE_W = 3;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);

  function automatic logic [CODE_W-1:0] step_code(input logic [CODE_W-1:0] code,
                                                  input logic              down);
    return down ? (code - CODE_ONE) : (code + CODE_ONE);
  endfunction

  function automatic logic wraps(input logic [CODE_W-1:0] code, input logic down);
    return down ? (code == '0) : (code == '1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// +----------------------------------------------------------------------------+
// | sync_edge : 2-flop synchronizer with a rising-edge detect from a 3rd flop   |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

`default_nettype wire

// File: rtl/code_sequencer.sv
// +----------------------------------------------------------------------------+
// | code_sequencer : 3-bit code generator (free-run / single-step / load)       |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module code_sequencer
  import code_seq_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              dir,
  input  logic              ld_en,
  input  logic [CODE_W-1:0] ld_val,
  output logic [CODE_W-1:0] data_out,
  output logic              valid,
  output logic              wrap
);

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  logic             run_lvl;
  logic             dir_lvl;
  logic             step_edge;
  logic             unused_rises;
  logic [DIV_W-1:0] presc;
  seq_state_t       state;
  logic             tick;
  logic             advance;
  logic             run_rise;
  logic             dir_rise;

  sync_edge u_run_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (run_sw),
    .level (run_lvl),
    .rise  (run_rise)
  );

  sync_edge u_dir_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (dir),
    .level (dir_lvl),
    .rise  (dir_rise)
  );

  sync_edge u_step_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (step_btn),
    .level (),
    .rise  (step_edge)
  );

  assign unused_rises = run_rise | dir_rise;

  // The second run_sw synchronizer flop doubles as the state register, so the
  // mode changes on the same edge the synchronized switch level does.
  assign state   = run_lvl ? RUN : HOLD;
  assign tick    = (state == RUN) && (presc == TICK_LAST);
  assign advance = (state == RUN) ? tick : step_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      valid    <= 1'b0;
      wrap     <= 1'b0;
      presc    <= '0;
    end else begin
      valid <= 1'b0;
      wrap  <= 1'b0;

      // A load restarts the tick period just like a tick does.
      if ((state == HOLD) || ld_en || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + DIV_ONE;
      end

      if (ld_en) begin
        data_out <= ld_val;
        valid    <= 1'b1;
      end else if (advance) begin
        data_out <= step_code(data_out, dir_lvl);
        valid    <= 1'b1;
        wrap     <= wraps(data_out, dir_lvl);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/code_sequencer.md
# code_sequencer

Upstream stimulus stage for the 3-bit decode/OR logic block. It generates the 3-bit code that drives that block's `data_in`, so the lab board can walk through all eight input codes. Codes advance automatically at a divided rate, by single-step button, or by direct load from switches. Board inputs are synchronized here, so the downstream combinational stage always sees a clean, registered code.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per automatic advance in RUN; must be ≥ 2.
- `DIV_W`, default 26: prescaler width; must satisfy 2^DIV_W ≥ TICK_DIV.

- `clk` in 1: single clock; all state is clocked on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run_sw` in 1: level input, asynchronous (board switch). 1 = free-run, 0 = hold.
- `step_btn` in 1: asynchronous, active-high pushbutton. Each rising edge advances once while in HOLD.
- `dir` in 1: asynchronous level. 0 = count up, 1 = count down.
- `ld_en` in 1: synchronous to `clk`. Loads `ld_val` into the code.
- `ld_val` in 3: value loaded when `ld_en` = 1.
- `data_out` out 3: registered code; connects to the decode/OR stage's `data_in`.
- `valid` out 1: one-cycle pulse in the cycle `data_out` takes a new value, whether by advance or load.
- `wrap` out 1: one-cycle pulse when an advance wraps: 7→0 counting up, or 0→7 counting down.

## Operation
- **Input synchronization:** `run_sw`, `step_btn` and `dir` each pass through 2 flops.
  - A third flop on `step_btn` gives the rising-edge pulse `step_edge = s2 & ~s3`.
- **States:**
  - HOLD: reset state. Entered when synced `run_sw` = 0.
  - RUN: entered when synced `run_sw` = 1.
- **Transitions:** evaluated every cycle from synced `run_sw`. Entering either state clears the prescaler to 0.
- **Prescaler (RUN only):** counts 0…TICK_DIV-1. `tick` is asserted when count = TICK_DIV-1, and the count then returns to 0. The prescaler is held at 0 in HOLD.
- **Advance:** `data_out` ← `data_out` ± 1 mod 8, using synced `dir` at the advance cycle.
- **Advance sources:**
  - `tick` in RUN.
  - `step_edge` in HOLD. `step_edge` is ignored in RUN.
- **Priority, highest first:** `rst` > `ld_en` > advance.
  - A load in the same cycle as a tick or step wins. The advance is dropped, not deferred.
  - A load also clears the prescaler.
  - `wrap` is never asserted on a load.
- **`valid`:** asserted for exactly one cycle per accepted load or advance, including a load of the same value.
- **Arithmetic:** 3-bit modulo arithmetic with no saturation.

## Timing
- **Reset:** asserting `rst` immediately forces the following, independent of `clk`:
  - Outputs: `data_out` = 0, `valid` = 0, `wrap` = 0.
  - Internal: state = HOLD, prescaler = 0, all sync flops = 0.
- **Reset mid-run:** aborts any pending tick or step. Operation restarts from HOLD on the first edge after release.
- **Load latency:** `ld_en` sampled high at edge k → `data_out` = `ld_val`, `valid` = 1 after edge k.
- **Step latency:** `step_btn` first sampled high at edge k → `data_out` updates at edge k+2, with `valid` (and `wrap` if applicable) high for the following cycle.
  - Holding the button causes no further advances.
- **Run start latency:** `run_sw` rising, first sampled at edge k → state = RUN after edge k+1. The first advance occurs TICK_DIV edges later; subsequent advances follow every TICK_DIV cycles.
- **Run stop latency:** `run_sw` falling → HOLD after 2 edges. A tick coinciding with the state change is not taken.
- **Direction change:** `dir` takes effect 2 edges after it changes.

## Structure
- **Package `code_seq_pkg`:**
  - `CODE_W = 3`.
  - `typedef enum logic {HOLD, RUN} seq_state_t`.
- **Sub-module `sync_edge`:** parameterless 2-flop synchronizer with a registered rising-edge output.
  - Instantiated for `step_btn`.
  - `run_sw` and `dir` use its synchronized level output only.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset, then idle for 10 cycles → `data_out` = 0, `valid` = 0, `wrap` = 0 throughout.
- `ld_en` = 1 with `ld_val` = 6 for one cycle → `data_out` = 6 the next cycle, `valid` pulse, no `wrap`.
- Load 6, HOLD, `dir` = 0, three step presses each 5 cycles long → codes 7, 0, 1.
  - Each code appears 2 edges after its press.
  - `wrap` is pulsed only on 7→0.
  - Exactly three `valid` pulses.
- `run_sw` = 1, `dir` = 1, starting from 1 → codes 0, 7, 6 spaced 4 cycles apart, with `wrap` on 0→7.
  - Set `run_sw` = 0 → counting stops within 2 cycles.
- In RUN, assert `ld_en` (`ld_val` = 3) in the tick cycle → `data_out` = 3, no advance.
  - The next advance occurs 4 cycles later.
- Assert `rst` mid-RUN, between clock edges → `data_out` = 0 immediately.
  - After release, stays in HOLD until `run_sw` is re-synchronized.
